// File: rtl/matmul_req_arbiter.sv
// matmul_req_arbiter
//   Shares one 3x3 constant-matrix multiply engine between NREQ requesters.
//   A granted requester's vector {x2,x1,x0} is captured, streamed serially into
//   the engine, and the three serial results y0,y1,y2 are forwarded back to the
//   requester side, tagged with the owner id. One transaction in flight at a time.
//
//   Build option: define MATMUL_ARB_FIXED_PRI_EN for fixed priority (lowest
//   asserted index wins). Left undefined, arbitration is round-robin.
//
// Ports
//   clk          clock, everything on posedge
//   rst          asynchronous active-low reset
//   req_valid    per-requester request
//   req_data     slice i = {x2,x1,x0} of requester i
//   req_ready    one-hot pulse: slice i captured this cycle
//   eng_in_en    engine input strobe
//   eng_datain   engine input element
//   eng_valid    engine output strobe
//   eng_multout  engine output element
//   res_valid    res_data valid this cycle
//   res_id       owner of res_data
//   res_data     result element (y0, y1, y2 in order)
//   res_last     marks y2
//   busy         high outside IDLE
//   err_timeout  one-cycle pulse on watchdog abort
module matmul_req_arbiter #(
    parameter int NREQ    = 2,
    parameter int DW      = 4,
    parameter int OW      = 10,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*3*DW-1:0]   req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   eng_in_en,
    output logic [DW-1:0]          eng_datain,
    input  logic                   eng_valid,
    input  logic [OW-1:0]          eng_multout,
    output logic                   res_valid,
    output logic [1:0]             res_id,
    output logic [OW-1:0]          res_data,
    output logic                   res_last,
    output logic                   busy,
    output logic                   err_timeout
);

    typedef enum logic [1:0] {IDLE, FEED, WAIT, COLLECT} state_t;

    localparam logic [7:0] TO_L = 8'(TIMEOUT);

    state_t          state, state_nxt;
    logic [1:0]      win_id;
    logic            win_found;
    logic            grant;
    logic            timeout_hit;
    logic [3*DW-1:0] sel_vec;
    logic [1:0]      id_q;
    logic [DW-1:0]   x0_q, x1_q, x2_q;
    logic [1:0]      feed_cnt;
    logic [1:0]      word_cnt;
    logic [7:0]      wd_cnt;

`ifdef MATMUL_ARB_FIXED_PRI_EN
    // Lowest asserted index wins: scan downward so the last hit is the lowest.
    always_comb begin
        win_found = 1'b0;
        win_id    = 2'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_found = 1'b1;
                win_id    = 2'(i);
            end
        end
    end
`else
    localparam logic [1:0] LAST_ID = 2'(NREQ - 1);

    logic [1:0] ptr;
    logic       hi_found;
    logic [1:0] hi_id;
    logic [1:0] lo_id;

    // Round-robin: lowest requester at or above ptr, else wrap to the lowest overall.
    always_comb begin
        hi_found  = 1'b0;
        hi_id     = 2'd0;
        lo_id     = 2'd0;
        win_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_found = 1'b1;
                lo_id     = 2'(i);
                if (2'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_id    = 2'(i);
                end
            end
        end
        win_id = hi_found ? hi_id : lo_id;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 2'd0;
        end else if (grant) begin
            ptr <= (win_id == LAST_ID) ? 2'd0 : win_id + 2'd1;
        end
    end
`endif

    // rst is folded in so req_ready stays quiet while reset is held.
    assign grant       = (state == IDLE) && win_found && rst;
    assign timeout_hit = ((state == WAIT) || (state == COLLECT)) && (wd_cnt == TO_L);

    always_comb begin
        sel_vec = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == 2'(i)) begin
                sel_vec = req_data[i*3*DW +: 3*DW];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant && (win_id == 2'(i));
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = FEED;
                end
            end
            FEED: begin
                if (feed_cnt == 2'd2) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (timeout_hit) begin
                    state_nxt = IDLE;
                end else if (eng_valid) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (timeout_hit) begin
                    state_nxt = IDLE;
                end else if (eng_valid && (word_cnt == 2'd2)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control counters and owner id
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            feed_cnt <= 2'd0;
            word_cnt <= 2'd0;
            wd_cnt   <= 8'd0;
            id_q     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    feed_cnt <= 2'd0;
                    if (grant) begin
                        id_q <= win_id;
                    end
                end
                FEED: begin
                    feed_cnt <= feed_cnt + 2'd1;
                    // Watchdog and word count start fresh on WAIT entry.
                    if (feed_cnt == 2'd2) begin
                        wd_cnt   <= 8'd0;
                        word_cnt <= 2'd0;
                    end
                end
                WAIT, COLLECT: begin
                    wd_cnt <= wd_cnt + 8'd1;
                    if (eng_valid && !timeout_hit) begin
                        word_cnt <= word_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Captured vector; only read while in FEED, so it needs no reset.
    always_ff @(posedge clk) begin
        if (grant) begin
            x0_q <= sel_vec[DW-1:0];
            x1_q <= sel_vec[2*DW-1:DW];
            x2_q <= sel_vec[3*DW-1:2*DW];
        end
    end

    // Output logic
    always_comb begin
        eng_in_en   = (state == FEED);
        eng_datain  = '0;
        if (state == FEED) begin
            case (feed_cnt)
                2'd0:    eng_datain = x0_q;
                2'd1:    eng_datain = x1_q;
                default: eng_datain = x2_q;
            endcase
        end
        // Abort takes precedence over a word arriving in the same cycle.
        res_valid   = ((state == WAIT) || (state == COLLECT)) && eng_valid && !timeout_hit;
        res_data    = res_valid ? eng_multout : '0;
        res_id      = res_valid ? id_q : 2'd0;
        res_last    = res_valid && (state == COLLECT) && (word_cnt == 2'd2);
        busy        = (state != IDLE);
        err_timeout = timeout_hit;
    end

endmodule
